// File: rtl/run_limit_bit_stuffer.sv
// Serializes DATA_W-bit words LSB first onto a 1-bit line, inserting a complementary
// stuff bit after every MAX_RUN identical line bits. Supports gap-free back-to-back words.
module run_limit_bit_stuffer #(
  parameter int DATA_W  = 8,
  parameter int MAX_RUN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_stuff,
  output logic              busy
);
  localparam int RUN_W = $clog2(MAX_RUN + 1);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_RUN);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DATA, STUFF} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              bit_q, bit_d;
  logic              vld_q, vld_d;
  logic              stf_q, stf_d;

  logic last_word, accept, do_load, do_adv, do_stuff, do_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      run_q   <= '0;
      bit_q   <= 1'b0;
      vld_q   <= 1'b0;
      stf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      bit_q   <= bit_d;
      vld_q   <= vld_d;
      stf_q   <= stf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    run_d    = run_q;
    bit_d    = bit_q;
    vld_d    = vld_q;
    stf_d    = stf_q;
    do_load  = 1'b0;
    do_adv   = 1'b0;
    do_stuff = 1'b0;
    do_idle  = 1'b0;

    last_word = (idx_q == IDX_LAST);
    in_ready  = (state_q == IDLE)
             || (state_q == DATA  && last_word && run_q != RUN_MAX)
             || (state_q == STUFF && last_word);
    accept    = in_valid && in_ready;

    case (state_q)
      IDLE:  do_load = accept;
      DATA: begin
        if (run_q == RUN_MAX) do_stuff = 1'b1;
        else if (!last_word)  do_adv   = 1'b1;
        else if (accept)      do_load  = 1'b1;
        else                  do_idle  = 1'b1;
      end
      STUFF: begin
        if (!last_word)  do_adv  = 1'b1;
        else if (accept) do_load = 1'b1;
        else             do_idle = 1'b1;
      end
      default: do_idle = 1'b1;
    endcase

    // Run history survives a word boundary only when the line never went idle.
    if (do_load) begin
      state_d = DATA;
      bit_d   = in_data[0];
      shreg_d = in_data >> 1;
      idx_d   = '0;
      vld_d   = 1'b1;
      stf_d   = 1'b0;
      run_d   = (state_q != IDLE && in_data[0] == bit_q) ? run_q + RUN_ONE : RUN_ONE;
    end
    if (do_adv) begin
      state_d = DATA;
      bit_d   = shreg_q[0];
      shreg_d = shreg_q >> 1;
      idx_d   = idx_q + IDX_W'(1);
      stf_d   = 1'b0;
      run_d   = (shreg_q[0] == bit_q) ? run_q + RUN_ONE : RUN_ONE;
    end
    if (do_stuff) begin
      state_d = STUFF;
      bit_d   = ~bit_q;
      stf_d   = 1'b1;
      run_d   = RUN_ONE;
    end
    if (do_idle) begin
      state_d = IDLE;
      bit_d   = 1'b0;
      vld_d   = 1'b0;
      stf_d   = 1'b0;
      run_d   = '0;
      idx_d   = '0;
    end
  end

  assign tx_bit   = bit_q;
  assign tx_valid = vld_q;
  assign tx_stuff = stf_q;
  assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_run_limit_bit_stuffer.sv
// Randomized + directed bench: a queue-based line model predicts every line cycle,
// plus an independent run-length monitor and destuff/reassembly check.
module tb_run_limit_bit_stuffer;
  localparam int DW = 8;
  localparam int MR = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready, tx_bit, tx_valid, tx_stuff, busy;

  run_limit_bit_stuffer #(.DATA_W(DW), .MAX_RUN(MR)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_stuff(tx_stuff), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: queue of pending line symbols {stuff,bit}; q[0] is what is on the line now.
  logic [1:0] q[$];
  logic       h_last;
  int         h_run;
  bit         acc_last;

  function automatic void encode(logic [DW-1:0] w);
    for (int i = 0; i < DW; i++) begin
      logic b;
      b = w[i];
      if (h_run > 0 && b == h_last) h_run++; else h_run = 1;
      h_last = b;
      q.push_back({1'b0, b});
      if (h_run == MR) begin
        h_last = ~b;
        h_run  = 1;
        q.push_back({1'b1, ~b});
      end
    end
  endfunction

  // Independent monitors
  logic          mon_last;
  int            mon_run = 0;
  int            viol = 0;
  bit            collect = 0;
  logic [DW-1:0] sent[$];
  logic [DW-1:0] got_w[$];
  logic [DW-1:0] acc_w;
  int            acc_n = 0;

  task automatic tick(bit v, logic [DW-1:0] d, bit r);
    bit mready;
    in_valid = v; in_data = d; rst = r;
    #1;
    mready = (q.size() <= 1);
    if (!r) chk("in_ready", in_ready, mready);
    @(posedge clk);
    acc_last = 0;
    if (r) begin
      q.delete(); h_run = 0;
    end else if (v && mready) begin
      acc_last = 1;
      if (q.size() == 0) h_run = 0;
      else void'(q.pop_front());
      encode(d);
      if (collect) sent.push_back(d);
    end else if (q.size() > 0) begin
      void'(q.pop_front());
      if (q.size() == 0) h_run = 0;
    end
    #1;
    if (q.size() > 0) begin
      chk("tx_valid", tx_valid, 1);
      chk("tx_bit",   tx_bit,   q[0][0]);
      chk("tx_stuff", tx_stuff, q[0][1]);
      chk("busy",     busy,     1);
    end else begin
      chk("idle_valid", tx_valid, 0);
      chk("idle_bit",   tx_bit,   0);
      chk("idle_stuff", tx_stuff, 0);
      chk("idle_busy",  busy,     0);
    end
    // run-length monitor and destuffer, fed only from DUT line outputs
    if (tx_valid) begin
      if (mon_run > 0 && tx_bit == mon_last) mon_run++; else mon_run = 1;
      mon_last = tx_bit;
      if (mon_run > MR) viol++;
      if (collect && !tx_stuff) begin
        acc_w[acc_n] = tx_bit;
        acc_n++;
        if (acc_n == DW) begin got_w.push_back(acc_w); acc_n = 0; end
      end
    end else mon_run = 0;
  endtask

  task automatic send(logic [DW-1:0] d);
    int k = 0;
    do begin tick(1, d, 0); k++; end while (!acc_last && k < 40);
    if (!acc_last) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(0, $urandom, 0);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = '0; h_run = 0; h_last = 0;
    tick(0, 0, 1);
    tick(0, 0, 1);
    idle(2);
    // all zeros: stuff every third bit, 12 line cycles
    send(8'h00); idle(14);
    // alternating words back to back, no stuffs
    send(8'h55); send(8'h55); idle(4);
    // history carried across a gap-free boundary
    send(8'hFF); send(8'h00); idle(14);
    // fresh run after the line idles
    send(8'h03); idle(3); send(8'hFC); idle(14);
    // reset in the middle of a word, then a clean word
    send(8'h00); idle(3);
    tick(0, 0, 1);
    idle(2);
    send(8'hA7); idle(14);
    // random phase
    collect = 1; acc_n = 0;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(3) == 0) idle($urandom_range(1, 4));
      else send($urandom);
    end
    idle(20);
    chk("run_violations", viol, 0);
    chk("word_count", got_w.size(), sent.size());
    for (int i = 0; i < sent.size() && i < got_w.size(); i++)
      chk("destuffed_word", got_w[i], sent[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
